// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: sequencer states, NOP encoding and the
// opcode bit that marks a two-word instruction.
package fetch_pkg;

    typedef enum logic {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } fetch_state_t;

    localparam logic [15:0] NOP_WORD     = 16'h0000;
    localparam int unsigned IMM_FLAG_BIT = 2;

    function automatic logic is_two_word(input logic [15:0] word);
        return word[IMM_FLAG_BIT];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction memory port, hazard/branch controls and the
// assembled instruction handed to decode.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [15:0]       mem_data;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instruction;
    logic [15:0]       immediate;
    logic              instr_valid;
    logic              has_imm;
    logic              wait_imm;

    modport master (
        input  mem_data, stall, flush, branch_target,
        output pc, instruction, immediate, instr_valid, has_imm, wait_imm
    );

    modport slave (
        output mem_data, stall, flush, branch_target,
        input  pc, instruction, immediate, instr_valid, has_imm, wait_imm
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter in 16-bit word units: reset load, branch redirect, stall
// hold, otherwise increment with natural wrap.
module fetch_pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (flush) begin
            pc <= branch_target;
        end else if (!stall) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC, pairs two-word opcodes with their
// immediate and presents one registered instruction per completed fetch.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       rst,
    fetch_sequencer_if.master bus
);

    fetch_state_t state, state_next;
    logic [15:0]  op_hold, op_hold_next;
    logic [15:0]  instr_q, instr_next;
    logic [15:0]  imm_q, imm_next;
    logic         valid_q, valid_next;
    logic         has_imm_q, has_imm_next;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .flush         (bus.flush),
        .stall         (bus.stall),
        .branch_target (bus.branch_target),
        .pc            (bus.pc)
    );

    always_comb begin
        state_next   = state;
        op_hold_next = op_hold;
        instr_next   = instr_q;
        imm_next     = imm_q;
        valid_next   = valid_q;
        has_imm_next = has_imm_q;

        // Flush outranks stall so a redirect is never lost behind a hazard.
        if (bus.flush) begin
            state_next   = FETCH_OP;
            op_hold_next = NOP_WORD;
            instr_next   = NOP_WORD;
            imm_next     = '0;
            valid_next   = 1'b0;
            has_imm_next = 1'b0;
        end else if (!bus.stall) begin
            unique case (state)
                FETCH_OP: begin
                    if (is_two_word(bus.mem_data)) begin
                        state_next   = FETCH_IMM;
                        op_hold_next = bus.mem_data;
                        instr_next   = NOP_WORD;
                        imm_next     = '0;
                        valid_next   = 1'b0;
                        has_imm_next = 1'b0;
                    end else begin
                        instr_next   = bus.mem_data;
                        imm_next     = '0;
                        valid_next   = 1'b1;
                        has_imm_next = 1'b0;
                    end
                end
                FETCH_IMM: begin
                    state_next   = FETCH_OP;
                    instr_next   = op_hold;
                    imm_next     = bus.mem_data;
                    valid_next   = 1'b1;
                    has_imm_next = 1'b1;
                end
                default: state_next = FETCH_OP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH_OP;
            op_hold   <= NOP_WORD;
            instr_q   <= NOP_WORD;
            imm_q     <= '0;
            valid_q   <= 1'b0;
            has_imm_q <= 1'b0;
        end else begin
            state     <= state_next;
            op_hold   <= op_hold_next;
            instr_q   <= instr_next;
            imm_q     <= imm_next;
            valid_q   <= valid_next;
            has_imm_q <= has_imm_next;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.immediate   = imm_q;
    assign bus.instr_valid = valid_q;
    assign bus.has_imm     = has_imm_q;
    assign bus.wait_imm    = (state == FETCH_IMM);

endmodule
